// File: rtl/servo_pwm_multi_if.sv
// Command/status bundle for servo_pwm_multi.
// master: the sequencer that issues start/pos_req; slave: the PWM generator.
interface servo_pwm_multi_if #(
    parameter int unsigned NUM_CH = 2
) ();

    logic              start;
    logic [NUM_CH-1:0] pos_req;
    logic              ready;
    logic              done;
    logic [NUM_CH-1:0] pwm_out;

    modport master (
        output start,
        output pos_req,
        input  ready,
        input  done,
        input  pwm_out
    );

    modport slave (
        input  start,
        input  pos_req,
        output ready,
        output done,
        output pwm_out
    );

endinterface

// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator with a start/ready/done handshake.
// Each channel drives a frame-synchronous PWM whose duty moves toward the
// commanded position only at frame boundaries, so no frame is ever truncated.
// Build option: define SERVO_SLEW_EN to limit the duty change to STEP ticks per
// frame; without it the duty jumps straight to the target at the next frame.
module servo_pwm_multi #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned CLK_EN_DIV = 5000,
    parameter int unsigned PERIOD     = 200,
    parameter int unsigned DUTY_UP    = 10,
    parameter int unsigned DUTY_DOWN  = 15,
    parameter int unsigned STEP       = 1
) (
    input  logic               clk,
    input  logic               reset,
    servo_pwm_multi_if.slave   bus
);

    localparam int unsigned DIV_W = (CLK_EN_DIV > 1) ? $clog2(CLK_EN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(PERIOD + 1);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_EN_DIV - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] DUTY_UP_V  = CNT_W'(DUTY_UP);
    localparam logic [CNT_W-1:0] DUTY_DN_V  = CNT_W'(DUTY_DOWN);

`ifdef SERVO_SLEW_EN
    // A step larger than the frame can never be used in full; clamp so it fits CNT_W.
    localparam int unsigned      STEP_C = (STEP > PERIOD) ? PERIOD : STEP;
    localparam logic [CNT_W-1:0] STEP_V = CNT_W'(STEP_C);
`endif

    // Parameter sanity checks at elaboration
    if (DUTY_UP > PERIOD) begin : g_err_duty_up
        $error("servo_pwm_multi: DUTY_UP must not exceed PERIOD");
    end
    if (DUTY_DOWN > PERIOD) begin : g_err_duty_down
        $error("servo_pwm_multi: DUTY_DOWN must not exceed PERIOD");
    end
    if (STEP < 1 || NUM_CH < 1 || CLK_EN_DIV < 1) begin : g_err_min
        $error("servo_pwm_multi: STEP, NUM_CH and CLK_EN_DIV must be at least 1");
    end

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [CNT_W-1:0]   r_duty   [NUM_CH];
    logic [CNT_W-1:0]   r_target [NUM_CH];
    logic [NUM_CH-1:0]  r_pwm;
    logic               r_done;

    logic               w_tick;
    logic               w_wrap;
    logic               w_accept;
    logic               w_finish;
    logic               w_all_match;
    logic [CNT_W-1:0]   w_duty_next [NUM_CH];

    assign w_tick = (r_div_cnt == DIV_LAST);
    assign w_wrap = w_tick && (r_frame_cnt == FRAME_LAST);

    // Post-wrap duty per channel, and whether every channel lands on its target
    always_comb begin
        w_all_match = 1'b1;
        for (int ch = 0; ch < int'(NUM_CH); ch++) begin
            w_duty_next[ch] = r_duty[ch];
`ifdef SERVO_SLEW_EN
            if (r_duty[ch] < r_target[ch]) begin
                if ((r_target[ch] - r_duty[ch]) > STEP_V) begin
                    w_duty_next[ch] = r_duty[ch] + STEP_V;
                end else begin
                    w_duty_next[ch] = r_target[ch];
                end
            end else if (r_duty[ch] > r_target[ch]) begin
                if ((r_duty[ch] - r_target[ch]) > STEP_V) begin
                    w_duty_next[ch] = r_duty[ch] - STEP_V;
                end else begin
                    w_duty_next[ch] = r_target[ch];
                end
            end
`else
            w_duty_next[ch] = r_target[ch];
`endif
            if (w_duty_next[ch] != r_target[ch]) begin
                w_all_match = 1'b0;
            end
        end
    end

    // Handshake FSM next state; completion is only counted while busy, so a
    // start landing on a wrap waits for the following wrap
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = StBusy;
                end
            end
            StBusy: begin
                if (w_wrap && w_all_match) begin
                    w_finish     = 1'b1;
                    w_state_next = StIdle;
                end
            end
        endcase
    end

    // Tick divider and frame counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div_cnt   <= '0;
            r_frame_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt   <= '0;
            r_frame_cnt <= (r_frame_cnt == FRAME_LAST) ? '0 : r_frame_cnt + CNT_W'(1);
        end else begin
            r_div_cnt   <= r_div_cnt + DIV_W'(1);
        end
    end

    // Per-channel target capture, frame-boundary duty update and PWM output
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int ch = 0; ch < int'(NUM_CH); ch++) begin
                r_duty[ch]   <= DUTY_UP_V;
                r_target[ch] <= DUTY_UP_V;
            end
            r_pwm <= '0;
        end else begin
            for (int ch = 0; ch < int'(NUM_CH); ch++) begin
                if (w_accept) begin
                    r_target[ch] <= bus.pos_req[ch] ? DUTY_UP_V : DUTY_DN_V;
                end
                if (w_wrap) begin
                    r_duty[ch] <= w_duty_next[ch];
                end
                r_pwm[ch] <= (r_frame_cnt < r_duty[ch]);
            end
        end
    end

    // FSM state and one-cycle done pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_finish;
        end
    end

    assign bus.ready   = (r_state == StIdle);
    assign bus.done    = r_done;
    assign bus.pwm_out = r_pwm;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Scoreboard bench for servo_pwm_multi. Stimulus pushes the expected done edge
// into a queue; a monitor compares pwm_out/ready every cycle against a
// closed-form model and pops the queue on each done pulse.
module tb_servo_pwm_multi;

    localparam int NUM_CH     = 2;
    localparam int CLK_EN_DIV = 2;
    localparam int PERIOD     = 20;
    localparam int DUTY_UP    = 2;
    localparam int DUTY_DOWN  = 5;
    localparam int STEP       = 1;
    localparam int FRAME      = PERIOD * CLK_EN_DIV;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #10 clk = ~clk;

    servo_pwm_multi_if #(.NUM_CH(NUM_CH)) bus ();

    servo_pwm_multi #(
        .NUM_CH    (NUM_CH),
        .CLK_EN_DIV(CLK_EN_DIV),
        .PERIOD    (PERIOD),
        .DUTY_UP   (DUTY_UP),
        .DUTY_DOWN (DUTY_DOWN),
        .STEP      (STEP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int n      = -1;   // index of the latest posedge since reset release

    // Model: each channel moves from m_a to m_b, one step per wrap after m_w1
    int m_a [NUM_CH];
    int m_b [NUM_CH];
    int m_w1;
    int m_s;
    int m_done_edge;
    bit m_op;
    int exp_done_q [$];

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, n, act, exp);
        end
    endfunction

    // Duty in force for the frame containing edge e
    function automatic int duty_at(int ch, int e);
        int steps;
        steps = (e <= m_w1) ? 0 : (e - m_w1 + FRAME - 1) / FRAME;
`ifdef SERVO_SLEW_EN
        begin
            int mag;
            int mv;
            mag = (m_b[ch] > m_a[ch]) ? m_b[ch] - m_a[ch] : m_a[ch] - m_b[ch];
            mv  = steps * STEP;
            if (mv > mag) mv = mag;
            return (m_b[ch] >= m_a[ch]) ? m_a[ch] + mv : m_a[ch] - mv;
        end
`else
        return (steps > 0) ? m_b[ch] : m_a[ch];
`endif
    endfunction

    function automatic void model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_a[ch] = DUTY_UP;
            m_b[ch] = DUTY_UP;
        end
        m_w1 = -1;
        m_s  = 0;
        m_done_edge = 0;
        m_op = 1'b0;
        exp_done_q.delete();
    endfunction

    task automatic wait_cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Called at a negedge; start is sampled by the DUT at the next posedge
    task automatic issue_start(input logic [NUM_CH-1:0] req);
        int s;
        int w1;
        int f;
        int a_new [NUM_CH];
        int b_new [NUM_CH];
        bus.start   = 1'b1;
        bus.pos_req = req;
        s = n + 1;
        if (!(m_op && s <= m_done_edge)) begin
            w1 = s - (s % FRAME) + FRAME - 1;
            if (w1 == s) w1 += FRAME;
            f = 1;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                a_new[ch] = duty_at(ch, w1);
                b_new[ch] = req[ch] ? DUTY_UP : DUTY_DOWN;
`ifdef SERVO_SLEW_EN
                begin
                    int mag;
                    int d;
                    mag = (b_new[ch] > a_new[ch]) ? b_new[ch] - a_new[ch] : a_new[ch] - b_new[ch];
                    d   = (mag + STEP - 1) / STEP;
                    if (d > f) f = d;
                end
`endif
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                m_a[ch] = a_new[ch];
                m_b[ch] = b_new[ch];
            end
            m_w1        = w1;
            m_s         = s;
            m_done_edge = w1 + FRAME * (f - 1);
            m_op        = 1'b1;
            exp_done_q.push_back(m_done_edge);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pulse_reset(input int cycles);
        reset = 1'b0;
        model_reset();
        wait_cycles(cycles);
        reset = 1'b1;
    endtask

    // Bounded wait for a done pulse, leaving the bench in the done cycle
    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while (!bus.done && k < bound) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!bus.done) begin
            errors++;
            $display("FAIL wait_done: no done within %0d cycles (got 0, expected 1)", bound);
        end
    endtask

    // Monitor: sample 1 time unit after each active edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                n = -1;
                check("rst_pwm", int'(bus.pwm_out), 0);
                check("rst_ready", int'(bus.ready), 1);
                check("rst_done", int'(bus.done), 0);
            end else begin
                logic [NUM_CH-1:0] ep;
                n++;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    ep[ch] = ((n % FRAME) / CLK_EN_DIV) < duty_at(ch, n);
                end
                check("pwm", int'(bus.pwm_out), int'(ep));
                check("ready", int'(bus.ready),
                      (m_op && n >= m_s && n < m_done_edge) ? 0 : 1);
                if (bus.done) begin
                    if (exp_done_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_unexpected at edge %0d: got 1, expected 0", n);
                    end else begin
                        check("done_edge", n, exp_done_q.pop_front());
                    end
                end else if (exp_done_q.size() > 0 && n >= exp_done_q[0]) begin
                    checks++;
                    errors++;
                    $display("FAIL done_missing: got none, expected at edge %0d",
                             exp_done_q.pop_front());
                end
            end
        end
    end

    initial begin
        bus.start   = 1'b0;
        bus.pos_req = '0;
        model_reset();
        wait_cycles(5);
        reset = 1'b1;
        wait_cycles(90);

        // Slew ch0 down, with an ignored start during the ramp
        issue_start(2'b10);
        wait_cycles(20);
        issue_start(2'b11);
        wait_cycles(150);

        // Back up, then a start in the done cycle
        issue_start(2'b11);
        wait_done(400);
        issue_start(2'b01);
        wait_cycles(10);

        // Reset after the first wrap of a ramp: no done, duty back to up
        wait_done(400);
        issue_start(2'b00);
        while ((n % FRAME) != FRAME / 2) @(negedge clk);
        wait_cycles(FRAME);
        pulse_reset(3);
        wait_cycles(200);

        // Start landing exactly on a wrap edge
        while ((n % FRAME) != FRAME - 2) @(negedge clk);
        issue_start(2'b01);
        wait_cycles(200);

        // Randomised starts with occasional resets
        repeat (40) begin
            wait_cycles($urandom_range(1, 130));
            if ($urandom_range(0, 9) == 0) begin
                pulse_reset($urandom_range(1, 5));
                wait_cycles(1);
            end else begin
                issue_start(NUM_CH'($urandom));
            end
        end
        wait_cycles(200);

        while (exp_done_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL done_pending: got none, expected at edge %0d", exp_done_q.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
